// File: rtl/key_cmd_pkg.sv
// Shared command codes and key bit positions for the key command queue.
package key_cmd_pkg;

   localparam int unsigned NUM_CMD = 5;

   localparam logic [2:0] CMD_UP      = 3'd0;
   localparam logic [2:0] CMD_DOWN    = 3'd1;
   localparam logic [2:0] CMD_LEFT    = 3'd2;
   localparam logic [2:0] CMD_RIGHT   = 3'd3;
   localparam logic [2:0] CMD_RESTART = 3'd4;

   localparam int unsigned KEY_UP_BIT      = 0;
   localparam int unsigned KEY_DOWN_BIT    = 1;
   localparam int unsigned KEY_LEFT_BIT    = 2;
   localparam int unsigned KEY_RIGHT_BIT   = 3;
   localparam int unsigned KEY_RESTART_BIT = 4;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO whose head is a register loaded one cycle after the entry lands (no bypass).
module cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic             valid,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign valid = valid_q;
   assign head  = head_q;

   always_comb begin
      do_pop   = pop & valid_q;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      // Entries pushed this cycle are not yet counted, so a fresh push shows up a cycle later.
      valid_d  = (count_q - CW'(do_pop)) != '0;
      head_d   = valid_d ? mem_q[rd_ptr_d] : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         head_q   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         head_q   <= head_d;
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
         end
      end
   end

endmodule

// File: rtl/key_cmd_queue.sv
// Turns debounced key presses into queued command codes for the game engine.
// Define KEY_CMD_REPEAT_EN to add auto-repeat on held arrow keys.
module key_cmd_queue
   import key_cmd_pkg::*;
#(
   parameter int unsigned KEY_W         = 18,
   parameter int unsigned DEPTH         = 4,
   parameter logic [23:0] REPEAT_DELAY  = 24'd5_000_000,
   parameter logic [23:0] REPEAT_PERIOD = 24'd2_500_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] key_in,
   input  logic             cmd_ready,
   output logic             cmd_valid,
   output logic [2:0]       cmd_code,
   output logic [4:0]       pending,
   output logic             drop
);

   logic [NUM_CMD-1:0] s1_q, s2_q, prev_q, pending_q, pending_d;
   logic [1:0]         warm_q, warm_d;
   logic               drop_q, drop_d;
   logic [NUM_CMD-1:0] edges, gnt, rep;
   logic               warm, can_push, push, pop, fifo_full, unused_fifo_empty;
   logic [2:0]         push_code;
   logic               unused_keys;

   assign unused_keys = ^key_in[KEY_W-1:NUM_CMD];
   assign warm        = (warm_q == 2'd3);
   assign pop         = cmd_valid & cmd_ready;
   assign can_push    = ~fifo_full | pop;
   assign pending     = pending_q;
   assign drop        = drop_q;

`ifdef KEY_CMD_REPEAT_EN
   logic [23:0] hold_q, hold_d;
   logic        held_one, changed;

   always_comb begin
      held_one = $onehot(s2_q[3:0]);
      changed  = (s2_q != prev_q);
      rep      = '0;
      hold_d   = '0;
      if (held_one) begin
         if (changed) begin
            hold_d = 24'd1;
         end else if (hold_q == REPEAT_DELAY) begin
            // Rewind so the next hit lands exactly one period later.
            rep    = {1'b0, s2_q[3:0]};
            hold_d = REPEAT_DELAY - REPEAT_PERIOD + 24'd1;
         end else begin
            hold_d = hold_q + 24'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
   assign rep = '0;
`endif

   always_comb begin
      warm_d = warm ? warm_q : warm_q + 2'd1;
      edges  = warm ? ((s2_q & ~prev_q) | rep) : '0;

      gnt       = '0;
      push      = 1'b0;
      push_code = CMD_UP;
      if (can_push) begin
         for (int unsigned i = 0; i < NUM_CMD; i++) begin
            if (pending_q[i] && !push) begin
               gnt[i]    = 1'b1;
               push      = 1'b1;
               push_code = 3'(i);
            end
         end
      end

      // A new edge wins over its own grant, so it is never lost.
      pending_d = edges | (pending_q & ~gnt);
      drop_d    = drop_q | (|(edges & pending_q & ~gnt));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         prev_q    <= '0;
         pending_q <= '0;
         warm_q    <= '0;
         drop_q    <= 1'b0;
      end else begin
         s1_q      <= key_in[NUM_CMD-1:0];
         s2_q      <= s1_q;
         prev_q    <= s2_q;
         pending_q <= pending_d;
         warm_q    <= warm_d;
         drop_q    <= drop_d;
      end
   end

   cmd_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(3)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_data(push_code),
      .pop      (pop),
      .full     (fifo_full),
      .empty    (unused_fifo_empty),
      .valid    (cmd_valid),
      .head     (cmd_code)
   );

endmodule

// File: tb/tb_key_cmd_queue.sv
// Directed self-checking bench for key_cmd_queue (default build, DEPTH=4).
module tb_key_cmd_queue;

   logic        clk;
   logic        rst;
   logic [17:0] key_in;
   logic        cmd_ready;
   logic        cmd_valid;
   logic [2:0]  cmd_code;
   logic [4:0]  pending;
   logic        drop;

   int n_checks = 0;
   int n_errors = 0;
   int n_got;
   logic [31:0] code_seq;

   key_cmd_queue u_dut (
      .clk      (clk),
      .rst      (rst),
      .key_in   (key_in),
      .cmd_ready(cmd_ready),
      .cmd_valid(cmd_valid),
      .cmd_code (cmd_code),
      .pending  (pending),
      .drop     (drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Pops with ready held high, recording each code as a nibble in code_seq.
   task automatic drain(input int cycles);
      cmd_ready = 1'b1;
      n_got     = 0;
      code_seq  = '0;
      repeat (cycles) begin
         if (cmd_valid && cmd_ready) begin
            n_got++;
            code_seq = {code_seq[27:0], 1'b0, cmd_code};
         end
         @(negedge clk);
      end
   endtask

   task automatic tap(input int idx);
      key_in      = '0;
      key_in[idx] = 1'b1;
      step(3);
      key_in = '0;
      step(3);
   endtask

   logic seen;

   initial begin
      rst       = 1'b1;
      key_in    = 18'h00001;
      cmd_ready = 1'b1;
      #1 rst = 1'b0;
      step(3);
      check_eq("rst_valid", cmd_valid, 0);
      check_eq("rst_code", cmd_code, 0);
      check_eq("rst_pending", pending, 0);
      check_eq("rst_drop", drop, 0);

      // Key held through reset release must stay silent.
      rst  = 1'b1;
      seen = 1'b0;
      repeat (100) begin
         step(1);
         seen = seen | cmd_valid | (|pending);
      end
      check_eq("warmup_quiet", seen, 0);
      key_in = '0;
      step(5);
      key_in = 18'h00001;
      drain(15);
      check_eq("warmup_count", n_got, 1);
      check_eq("warmup_code", code_seq, 32'h0);

      // Single press latency.
      key_in = '0;
      step(5);
      key_in = 18'h00008;
      step(4);
      check_eq("single_k3_valid", cmd_valid, 0);
      step(1);
      check_eq("single_k4_valid", cmd_valid, 1);
      check_eq("single_k4_code", cmd_code, 3);
      step(1);
      check_eq("single_k5_valid", cmd_valid, 0);
      key_in = 18'h3FFE0;
      step(3);
      key_in = 18'h15540;
      step(3);
      key_in = '0;
      drain(15);
      check_eq("upper_bits_count", n_got, 0);

      // Simultaneous DOWN, LEFT, RESTART.
      key_in = 18'h00016;
      step(3);
      check_eq("simul_pend0", pending, 5'b10110);
      step(1);
      check_eq("simul_pend1", pending, 5'b10100);
      check_eq("simul_k3_valid", cmd_valid, 0);
      step(1);
      check_eq("simul_pend2", pending, 5'b10000);
      check_eq("simul_code1", {cmd_valid, cmd_code}, 4'b1001);
      step(1);
      check_eq("simul_pend3", pending, 5'b00000);
      check_eq("simul_code2", {cmd_valid, cmd_code}, 4'b1010);
      step(1);
      check_eq("simul_code4", {cmd_valid, cmd_code}, 4'b1100);
      step(1);
      check_eq("simul_end_valid", cmd_valid, 0);
      key_in = '0;
      step(5);

      // Backpressure: four fill the FIFO, RESTART waits, a second RESTART drops.
      cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) tap(i);
      step(5);
      check_eq("bp_head", {cmd_valid, cmd_code}, 4'b1000);
      check_eq("bp_pending", pending, 5'b10000);
      check_eq("bp_drop0", drop, 0);
      tap(4);
      step(3);
      check_eq("bp_drop1", drop, 1);
      check_eq("bp_pending2", pending, 5'b10000);
      drain(15);
      check_eq("bp_count", n_got, 5);
      check_eq("bp_seq", code_seq, 32'h01234);
      check_eq("bp_end_valid", cmd_valid, 0);
      check_eq("bp_end_pending", pending, 0);

      // Full FIFO with UP pending: one pop lets UP in while the count stays full.
      cmd_ready = 1'b0;
      for (int i = 1; i < 5; i++) tap(i);
      tap(0);
      step(3);
      check_eq("full_pending", pending, 5'b00001);
      check_eq("full_head", cmd_code, 1);
      cmd_ready = 1'b1;
      step(1);
      cmd_ready = 1'b0;
      check_eq("full_pp_head", {cmd_valid, cmd_code}, 4'b1010);
      check_eq("full_pp_pending", pending, 0);
      tap(3);
      step(3);
      check_eq("full_still", pending, 5'b01000);
      drain(15);
      check_eq("full_count", n_got, 5);
      check_eq("full_seq", code_seq, 32'h23403);

      // Asynchronous reset in the middle of traffic.
      cmd_ready = 1'b0;
      step(3);
      key_in = 18'h0000F;
      step(6);
      check_eq("mid_pending", pending, 5'b01000);
      check_eq("mid_head", {cmd_valid, cmd_code}, 4'b1000);
      check_eq("mid_drop", drop, 1);
      #2 rst = 1'b0;
      #1;
      check_eq("mid_rst_valid", cmd_valid, 0);
      check_eq("mid_rst_pending", pending, 0);
      check_eq("mid_rst_drop", drop, 0);
      rst = 1'b1;
      step(1);
      drain(20);
      check_eq("mid_held_count", n_got, 0);
      check_eq("mid_held_pending", pending, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
